// File: rtl/rtc_bus_cycle_driver.sv
// RTC multiplexed address/data bus cycle driver: turns the timing counter's phase
// index into cs_n/rd_n/wr_n/a_d/AD pad activity for one register read or write.
module rtc_bus_cycle_driver #(
    parameter int unsigned DATA_W     = 8,
    parameter logic [3:0]  CAPTURE_PH = 4'd7,
    parameter logic [3:0]  LAST_PH    = 4'd11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_rd,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        phase,
    input  logic [DATA_W-1:0] ad_in,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              a_d,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              abort
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    typedef struct packed {
        logic              cs_n;
        logic              rd_n;
        logic              wr_n;
        logic              a_d;
        logic              oe;
        logic [DATA_W-1:0] ad;
    } pins_t;

    state_t            state;
    logic [3:0]        phase_q;
    pins_t             pins_q;
    logic              cmd_rd;
    logic [DATA_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic enter_zero;
    logic cycle_end;
    logic cycle_bad;
    logic capture_now;

    function automatic pins_t idle_pins();
        pins_t p;
        p.cs_n = 1'b1;
        p.rd_n = 1'b1;
        p.wr_n = 1'b1;
        p.a_d  = 1'b1;
        p.oe   = 1'b0;
        p.ad   = '0;
        return p;
    endfunction

    function automatic pins_t run_pins(input logic [3:0]        ph,
                                       input logic              rd,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] d);
        pins_t p;
        // NOTE: every field is defaulted before the case, so no path can leave a field unassigned (no latch).
        p     = idle_pins();
        p.a_d = 1'b0;
        case (ph)
            4'd1, 4'd2: begin
                p.cs_n = 1'b0;
                p.wr_n = 1'b0;
                p.oe   = 1'b1;
                p.ad   = a;
            end
            4'd3: begin
                p.oe = 1'b1;
                p.ad = a;
            end
            4'd4: p.a_d = 1'b1;
            4'd5, 4'd7: begin
                p.cs_n = 1'b0;
                p.a_d  = 1'b1;
                p.oe   = !rd;
                p.ad   = rd ? '0 : d;
            end
            4'd6: begin
                p.cs_n = 1'b0;
                p.a_d  = 1'b1;
                p.oe   = !rd;
                p.ad   = rd ? '0 : d;
                p.rd_n = !rd;
                p.wr_n = rd;
            end
            4'd8: begin
                p.a_d = 1'b1;
                p.oe  = !rd;
                p.ad  = rd ? '0 : d;
            end
            4'd9: p.a_d = 1'b1;
            default: ;
        endcase
        // The RTC owns the AD lines while rd_n is low; never fight it.
        if (!p.rd_n) begin
            p.oe = 1'b0;
            p.ad = '0;
        end
        return p;
    endfunction

    assign enter_zero  = (phase == 4'd0) && (phase_q != 4'd0);
    assign cycle_end   = (phase == 4'd0) && (phase_q == LAST_PH);
    assign cycle_bad   = (enter_zero && !cycle_end) || (phase > LAST_PH);
    assign capture_now = cmd_rd && (phase == CAPTURE_PH) && (phase_q != CAPTURE_PH);

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            phase_q  <= 4'd0;
            pins_q   <= idle_pins();
            rd_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
            cmd_rd   <= 1'b0;
            cmd_addr <= '0;
            cmd_data <= '0;
        end else begin
            phase_q <= phase;
            done    <= 1'b0;
            abort   <= 1'b0;
            case (state)
                IDLE: begin
                    pins_q <= idle_pins();
                    if (start) begin
                        state    <= ARM;
                        busy     <= 1'b1;
                        cmd_rd   <= op_rd;
                        cmd_addr <= addr;
                        cmd_data <= wr_data;
                    end
                end
                ARM: begin
                    pins_q <= idle_pins();
                    if (enter_zero) state <= RUN;
                end
                RUN: begin
                    if (cycle_end) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pins_q <= idle_pins();
                    end else if (cycle_bad) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        abort  <= 1'b1;
                        pins_q <= idle_pins();
                    end else begin
                        pins_q <= run_pins(phase, cmd_rd, cmd_addr, cmd_data);
                        if (capture_now) rd_data <= ad_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cs_n   = pins_q.cs_n;
    assign rd_n   = pins_q.rd_n;
    assign wr_n   = pins_q.wr_n;
    assign a_d    = pins_q.a_d;
    assign ad_oe  = pins_q.oe;
    assign ad_out = pins_q.ad;

endmodule

// File: tb/tb_rtc_bus_cycle_driver.sv
// Self-checking bench for rtc_bus_cycle_driver: a vector table for a full write,
// directed corner sequences, then random phase/command traffic against a model.
module tb_rtc_bus_cycle_driver;

    logic       clk = 1'b0;
    logic       reset, start, op_rd;
    logic [7:0] addr, wr_data, ad_in;
    logic [3:0] phase;
    logic [7:0] ad_out, rd_data;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done, abort;

    int    errs   = 0;
    int    checks = 0;
    string tag    = "init";

    always #5 clk = ~clk;

    rtc_bus_cycle_driver dut (
        .clk(clk), .reset(reset), .start(start), .op_rd(op_rd), .addr(addr),
        .wr_data(wr_data), .phase(phase), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .rd_data(rd_data), .busy(busy), .done(done), .abort(abort)
    );

    // Per-phase pin levels while a cycle runs, bit index = phase.
    logic [11:0] cs_pat    = 12'b1111_0001_1001;
    logic [11:0] wr_pat_w  = 12'b1111_1011_1001;
    logic [11:0] wr_pat_r  = 12'b1111_1111_1001;
    logic [11:0] rd_pat_r  = 12'b1111_1011_1111;
    logic [11:0] ad_pat    = 12'b0011_1111_0000;
    logic [11:0] oe_pat_w  = 12'b0001_1110_1110;
    logic [11:0] oe_pat_r  = 12'b0000_0000_1110;

    // Model state: waiting for the counter to relaunch, or a cycle in flight.
    bit         m_wait, m_live, m_rd;
    logic [7:0] m_addr, m_data;
    logic [3:0] m_prev;
    logic       e_cs_n, e_rd_n, e_wr_n, e_a_d, e_oe, e_busy, e_done, e_abort;
    logic [7:0] e_ad, e_rd_data;

    typedef struct {
        logic       start;
        logic [3:0] phase;
        logic       cs_n, rd_n, wr_n, a_d, oe;
        logic [7:0] ad_out;
        logic       busy, done;
    } vec_t;

    vec_t tv[15];

    function automatic logic [31:0] b1(input logic x);
        return {31'd0, x};
    endfunction

    function automatic logic [31:0] act_pack();
        return {8'd0, cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, abort, ad_out, rd_data};
    endfunction

    function automatic logic [31:0] exp_pack();
        return {8'd0, e_cs_n, e_rd_n, e_wr_n, e_a_d, e_oe, e_busy, e_done, e_abort, e_ad, e_rd_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle_pins();
        e_cs_n = 1'b1; e_rd_n = 1'b1; e_wr_n = 1'b1; e_a_d = 1'b1; e_oe = 1'b0; e_ad = 8'h00;
    endtask

    // Computes what the pins should show after the coming edge, from the current inputs.
    task automatic model_update();
        bit was_live, enter0;
        e_done  = 1'b0;
        e_abort = 1'b0;
        if (reset) begin
            m_wait = 0; m_live = 0; m_prev = 4'd0;
            e_rd_data = 8'h00; e_busy = 1'b0;
            set_idle_pins();
        end else begin
            enter0   = (phase == 4'd0) && (m_prev != 4'd0);
            was_live = m_live;
            if (m_live) begin
                if (phase == 4'd0 && m_prev == 4'd11) begin
                    m_live = 0; e_done = 1'b1;
                end else if (phase > 4'd11 || enter0) begin
                    m_live = 0; e_abort = 1'b1;
                end else if (m_rd && phase == 4'd7 && m_prev != 4'd7) begin
                    e_rd_data = ad_in;
                end
            end else if (m_wait) begin
                if (enter0) begin m_wait = 0; m_live = 1; end
            end else if (start) begin
                m_wait = 1; m_rd = op_rd; m_addr = addr; m_data = wr_data;
            end
            e_busy = m_wait || m_live;
            m_prev = phase;
            if (was_live && m_live) begin
                e_cs_n = cs_pat[phase];
                e_a_d  = ad_pat[phase];
                e_wr_n = m_rd ? wr_pat_r[phase] : wr_pat_w[phase];
                e_rd_n = m_rd ? rd_pat_r[phase] : 1'b1;
                e_oe   = m_rd ? oe_pat_r[phase] : oe_pat_w[phase];
                if (phase >= 4'd1 && phase <= 4'd3)                 e_ad = m_addr;
                else if (!m_rd && phase >= 4'd5 && phase <= 4'd8)  e_ad = m_data;
                else                                                e_ad = 8'h00;
            end else begin
                set_idle_pins();
            end
        end
    endtask

    task automatic step();
        logic [3:0] ph;
        ph = phase;
        model_update();
        @(posedge clk);
        #1;
        check($sformatf("%s model ph%0d", tag, ph), act_pack(), exp_pack());
        check($sformatf("%s oe_vs_rd_n ph%0d", tag, ph), b1(ad_oe & ~rd_n), 32'd0);
    endtask

    task automatic cmd(input logic st, input logic rd, input logic [7:0] a, input logic [7:0] d);
        start = st; op_rd = rd; addr = a; wr_data = d;
    endtask

    task automatic ph_step(input logic [3:0] p);
        phase = p;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_rd = 1'b0; addr = 8'h00; wr_data = 8'h00;
        ad_in = 8'h00; phase = 4'd0;
        m_rd = 0; m_addr = 8'h00; m_data = 8'h00;

        tag = "reset";
        step();
        step();
        check("reset pins", act_pack(), {8'd0, 8'b1111_0000, 16'h0000});
        reset = 1'b0;

        // Test 1: full write cycle, expectations derived by hand.
        tv[0]  = '{1'b1, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 4'd4,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 4'd5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 4'd6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 4'd8,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0};
        tv[10] = '{1'b0, 4'd9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[11] = '{1'b0, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[12] = '{1'b0, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[14] = '{1'b0, 4'd1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tag = "t1";
        for (int i = 0; i < 15; i++) begin
            cmd(tv[i].start, 1'b0, 8'h21, 8'h45);
            phase = tv[i].phase;
            step();
            check($sformatf("t1 vec%0d", i), act_pack(),
                  {8'd0, tv[i].cs_n, tv[i].rd_n, tv[i].wr_n, tv[i].a_d, tv[i].oe,
                   tv[i].busy, tv[i].done, 1'b0, tv[i].ad_out, 8'h00});
        end
        start = 1'b0;

        // Test 2: read with capture at phase 7 entry.
        tag = "t2";
        cmd(1'b1, 1'b1, 8'h22, 8'h00);
        ph_step(4'd2);
        for (int p = 3; p <= 11; p++) ph_step(4'(p));
        for (int p = 0; p <= 11; p++) begin
            ad_in = (p == 7) ? 8'h37 : 8'($urandom);
            ph_step(4'(p));
            check($sformatf("t2 rd_n ph%0d", p), b1(rd_n), b1(p != 6));
            if (p == 6 || p == 7) check($sformatf("t2 ad_oe ph%0d", p), b1(ad_oe), 32'd0);
        end
        ad_in = 8'h5C;
        ph_step(4'd0);
        check("t2 done", b1(done), 32'd1);
        check("t2 rd_data", {24'd0, rd_data}, 32'h37);
        ph_step(4'd1);
        check("t2 busy after", b1(busy), 32'd0);
        check("t2 done once", b1(done), 32'd0);

        // Test 3: phase jumps 6->0 in the middle of a read.
        tag = "t3";
        cmd(1'b1, 1'b1, 8'h5A, 8'h00);
        ph_step(4'd11);
        ad_in = 8'hC3;
        for (int p = 0; p <= 6; p++) ph_step(4'(p));
        ph_step(4'd0);
        check("t3 abort", b1(abort), 32'd1);
        check("t3 no done", b1(done), 32'd0);
        check("t3 strobes", {29'd0, cs_n, rd_n, wr_n}, 32'd7);
        check("t3 ad_oe", b1(ad_oe), 32'd0);
        check("t3 rd_data kept", {24'd0, rd_data}, 32'h37);
        ph_step(4'd0);
        check("t3 abort pulse", b1(abort), 32'd0);

        // Test 4: second start mid-cycle must not disturb the latched command.
        tag = "t4";
        cmd(1'b1, 1'b0, 8'h3C, 8'h5E);
        ph_step(4'd0);
        for (int p = 1; p <= 11; p++) ph_step(4'(p));
        ph_step(4'd0);
        for (int p = 1; p <= 11; p++) begin
            if (p == 5) cmd(1'b1, 1'b1, 8'hAA, 8'hBB);
            ph_step(4'(p));
            if (p == 2) check("t4 addr", {24'd0, ad_out}, 32'h3C);
            if (p == 6) begin
                check("t4 data", {24'd0, ad_out}, 32'h5E);
                check("t4 wr_n", b1(wr_n), 32'd0);
            end
        end
        ph_step(4'd0);
        check("t4 done", b1(done), 32'd1);
        ph_step(4'd1);
        check("t4 stray start ignored", b1(busy), 32'd0);

        // Test 5: reset in phase 6 of a write.
        tag = "t5";
        cmd(1'b1, 1'b0, 8'h11, 8'h77);
        ph_step(4'd11);
        for (int p = 0; p <= 6; p++) ph_step(4'(p));
        reset = 1'b1;
        ph_step(4'd6);
        check("t5 reset pins", act_pack(), {8'd0, 8'b1111_0000, 16'h0000});
        reset = 1'b0;

        // Test 6: start while the counter is mid-period waits for phase 0 entry.
        tag = "t6";
        ph_step(4'd3);
        cmd(1'b1, 1'b0, 8'h66, 8'h99);
        ph_step(4'd4);
        check("t6 armed busy", b1(busy), 32'd1);
        for (int p = 5; p <= 11; p++) begin
            ph_step(4'(p));
            check($sformatf("t6 idle cs_n ph%0d", p), b1(cs_n), 32'd1);
            check($sformatf("t6 idle oe ph%0d", p), b1(ad_oe), 32'd0);
        end
        for (int p = 0; p <= 11; p++) ph_step(4'(p));
        ph_step(4'd0);
        check("t6 done", b1(done), 32'd1);

        // Random traffic: counter mostly steps, sometimes dwells or jumps.
        tag = "rand";
        begin
            logic [3:0] ph;
            ph = 4'd0;
            for (int i = 0; i < 1000; i++) begin
                int r;
                r = $urandom_range(99);
                if (r < 3)       ph = 4'($urandom_range(15));
                else if (r < 28) ph = ph;
                else             ph = (ph >= 4'd11) ? 4'd0 : ph + 4'd1;
                reset   = ($urandom_range(149) == 0);
                start   = ($urandom_range(5) == 0);
                op_rd   = 1'($urandom_range(1));
                addr    = 8'($urandom);
                wr_data = 8'($urandom);
                ad_in   = 8'($urandom);
                phase   = ph;
                step();
            end
        end
        reset = 1'b0;
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
